// File: rtl/multicycle_main_fsm_pkg.sv
// Shared encodings for the multicycle main control FSM and its downstream alu_decoder.
// State codes are visible on the debug port, so their values are fixed.
package multicycle_main_fsm_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
    StJal      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  function automatic logic is_legal_op(logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) || (op == OP_I) ||
           (op == OP_BEQ) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle core: fetch/decode/execute/memory/writeback sequencing
// with a mem_ready handshake that stretches FETCH, MEMREAD and MEMWRITE.
module multicycle_main_fsm
  import multicycle_main_fsm_pkg::*;
#(
  parameter int unsigned OP_W    = 7,
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic [1:0]         ALUOp,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic               AdrSrc,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               PCWrite,
  output logic               illegal_instr,
  output logic [STATE_W-1:0] state_o
);

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:    if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_R:         state_d = StExecR;
          OP_I:         state_d = StExecI;
          OP_BEQ:       state_d = StBeq;
          OP_JAL:       state_d = StJal;
          default:      state_d = StFetch;
        endcase
      end
      StMemAdr:   state_d = (opcode == OP_LW) ? StMemRead : StMemWrite;
      StMemRead:  if (mem_ready) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (mem_ready) state_d = StFetch;
      StExecR:    state_d = StAluWb;
      StExecI:    state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBeq:      state_d = StFetch;
      StJal:      state_d = StAluWb;
      default:    state_d = StFetch;
    endcase
  end

  always_comb begin
    ALUOp         = ALUOP_ADD;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_RD2;
    ResultSrc     = RES_ALUOUT;
    AdrSrc        = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    MemWrite      = 1'b0;
    PCWrite       = 1'b0;
    illegal_instr = 1'b0;
    case (state_q)
      StFetch: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      StDecode: begin
        // ALU precomputes the branch target OldPC + imm while the opcode is decoded.
        ALUSrcA       = SRCA_OLDPC;
        ALUSrcB       = SRCB_IMM;
        illegal_instr = ~is_legal_op(opcode);
      end
      StMemAdr: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      StMemRead: begin
        AdrSrc = 1'b1;
      end
      StMemWb: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      StMemWrite: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      StExecR: begin
        ALUSrcA = SRCA_RD1;
        ALUOp   = ALUOP_FUNCT;
      end
      StExecI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
      end
      StAluWb: begin
        RegWrite = 1'b1;
      end
      StBeq: begin
        ALUSrcA = SRCA_RD1;
        ALUOp   = ALUOP_SUB;
        PCWrite = zero;
      end
      StJal: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
    // Reset aborts any in-flight instruction: present FETCH selects with every write disabled.
    if (rst) begin
      ALUOp         = ALUOP_ADD;
      ALUSrcA       = SRCA_PC;
      ALUSrcB       = SRCB_FOUR;
      ResultSrc     = RES_ALURESULT;
      AdrSrc        = 1'b0;
      IRWrite       = 1'b0;
      RegWrite      = 1'b0;
      MemWrite      = 1'b0;
      PCWrite       = 1'b0;
      illegal_instr = 1'b0;
    end
  end

  assign state_o = STATE_W'(state_q);

endmodule
